c2h_queue_scheduler: RTL and testbench
======================================

// Module: c2h_queue_scheduler
// PURPOSE
//  Credit-based round-robin scheduler that shares the C2H traffic generator among up to NUM_Q queues.
//  - Tracks per-queue descriptor credits from QDMA credit updates.
//  - Selects the next eligible queue and grants it to the generator; the generator stamps rx_qid with the grant.
//  - Holds the grant until the generator reports the packet's last beat, then re-arbitrates.
// PARAMETERS
//  NUM_Q        8   number of queue slots tracked (power of 2, 2..32)
//  TM_DSC_BITS  16  credit_in width; per-queue credit counters are also TM_DSC_BITS wide
//  QID_W        11  queue id width
// PORTS
//  axi_aclk        in   1            clock
//  axi_areset      in   1            synchronous reset, active-high
//  sched_en        in   1            run enable; low = drain and clear
//  qid_base        in   QID_W        first qid of the queue window
//  num_queue       in   QID_W        active queues, 1..NUM_Q; 0 treated as 1, >NUM_Q clamped to NUM_Q
//  credit_updt     in   1            credit_in/credit_qid valid this cycle
//  credit_qid      in   QID_W        queue receiving credits
//  credit_in       in   TM_DSC_BITS  credits (packets) to add
//  grant_valid     out  1            grant offered to generator
//  grant_qid       out  QID_W        granted queue id (qid_base + slot)
//  grant_ready     in   1            generator accepts grant (starts packet)
//  pkt_valid       in   1            generator beat valid (rx_valid)
//  pkt_ready       in   1            sink ready (rx_ready)
//  pkt_last        in   1            generator last beat (rx_last)
//  credit_avail    out  NUM_Q        bit i = slot i credit counter nonzero
//  bad_credit_cnt  out  16           credit updates with qid outside window, saturating
// BEHAVIOUR
//  - Reset values: grant_valid=0, grant_qid=0, credit_avail=0, bad_credit_cnt=0.
//    All credit counters=0, rr_ptr=0, state=IDLE.
//  - States:
//    - IDLE: wait for sched_en=1, then go to ARB.
//    - ARB (1 cycle): scan slots rr_ptr..rr_ptr+num_queue-1, wrapping modulo num_queue.
//      - First slot with credit>0 wins: register grant_qid, go to GRANT.
//      - No eligible slot: stay in ARB.
//    - GRANT: grant_valid=1; grant_qid stays stable until accepted.
//      - grant_valid & grant_ready: decrement the slot's credit, set rr_ptr=(slot+1)%num_queue, go to BUSY.
//      - sched_en=0 with no accept: drop grant (no credit consumed), go to IDLE.
//    - BUSY: grant_valid=0; pkt_valid & pkt_ready & pkt_last goes to ARB, or to IDLE if sched_en=0.
//      An in-flight packet always completes.
//  - Latency:
//    - Credit update registered in cycle N is visible to ARB in cycle N+1.
//    - ARB entry to grant_valid=1 is 1 cycle.
//    - Back-to-back packets: pkt_last accepted -> ARB -> GRANT, minimum 2 idle cycles.
//  - Credit arithmetic:
//    - slot = credit_qid - qid_base, computed in QID_W.
//    - Valid only if credit_qid >= qid_base and slot < num_queue.
//    - Otherwise ignored, and bad_credit_cnt increments (saturates at 16'hFFFF).
//  - Same slot, same cycle, update and grant accept: new = old + credit_in - 1.
//  - Counters saturate at all-ones on add and never underflow; grant requires credit>0.
//  - sched_en=0: all credit counters and rr_ptr clear every cycle; credit updates ignored, bad_credit_cnt unaffected.
//  - num_queue change takes effect at the next ARB.
//    - rr_ptr >= num_queue wraps to 0.
//    - Slots >= num_queue keep their credits but are never eligible.
//  - credit_avail is registered from the counters and updates 1 cycle after each counter change.
//  - axi_areset mid-packet returns everything to reset values next cycle; the generator must be reset alongside.
// CONFIGURATION
//  SCHED_STATS_EN defined:
//    - Adds output grant_cnt [NUM_Q*32-1:0], one 32-bit counter per slot, slot i at bits [32*i+:32].
//    - Counter increments on each accepted grant, wraps at 2^32, clears on reset only.
//  SCHED_STATS_EN undefined: port and counters absent; all other behaviour identical.
// TESTING
//  1. Reset with sched_en=1, no credits -> grant_valid stays 0 for 100 cycles, credit_avail=0.
//  2. num_queue=4, qid_base=8; credit 2 to each of qids 8..11, grant_ready=1, 1-beat pkts
//     -> grant order 8,9,10,11,8,9,10,11, then idle; credit_avail returns to 0.
//  3. Credit 1 to qid 20 with qid_base=8, num_queue=4
//     -> no grant, bad_credit_cnt=1; repeat 70000 times -> saturates at 16'hFFFF.
//  4. Slot 0 credit=1; credit_updt +3 on qid_base in the same cycle grant is accepted
//     -> slot 0 credit=3, then 3 more grants to slot 0.
//  5. Drop sched_en mid-packet (BUSY)
//     -> packet completes through pkt_last, then IDLE; all credits 0, next grant only after new credits.
//  6. SCHED_STATS_EN build, scenario 2 -> grant_cnt slots 0..3 each = 2, slots 4..7 = 0.

Source files
------------

// File: rtl/c2h_queue_scheduler.sv
// c2h_queue_scheduler
//   Credit-based round-robin scheduler that shares one C2H traffic generator
//   among up to NUM_Q queue slots. Per-slot descriptor credits are loaded from
//   QDMA credit updates. The scheduler grants the next eligible slot and holds
//   that grant until the generator reports the packet's last beat.
//
//   Optional feature macro: SCHED_STATS_EN adds per-slot accepted-grant
//   counters on the grant_cnt port.
//
// Ports
//   axi_aclk, axi_areset      clock, synchronous active-high reset
//   sched_en                  run enable; low clears credits and rr pointer
//   qid_base, num_queue       queue window (num_queue 0 -> 1, >NUM_Q -> NUM_Q)
//   credit_updt/_qid/_in      credit update strobe, target qid, amount
//   grant_valid/_qid/_ready   grant handshake to the generator
//   pkt_valid/_ready/_last    generator beat stream (end-of-packet detect)
//   credit_avail              per-slot "credit counter nonzero", registered
//   bad_credit_cnt            out-of-window credit updates, saturating
//   grant_cnt                 (SCHED_STATS_EN) 32-bit accepted grants per slot

// One slot's credit counter. Adds saturate at all-ones, and the decrement
// never goes below zero.
module c2h_qs_slot #(
    parameter int CW = 16
) (
    input  logic          axi_aclk,
    input  logic          axi_areset,
    input  logic          clr,
    input  logic          add_en,
    input  logic [CW-1:0] add_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          avail
);
    // Two extra bits: [CW] flags overflow, [CW+1] flags underflow.
    logic [CW+1:0] nxt;

    always_comb begin
        nxt = {2'b00, cnt} + (add_en ? {2'b00, add_val} : '0) - {{(CW+1){1'b0}}, dec};
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            cnt   <= '0;
            avail <= 1'b0;
        end else begin
            avail <= |cnt;
            if (clr)              cnt <= '0;
            else if (nxt[CW+1])   cnt <= '0;
            else if (nxt[CW])     cnt <= '1;
            else                  cnt <= nxt[CW-1:0];
        end
    end
endmodule

module c2h_queue_scheduler #(
    parameter int NUM_Q       = 8,
    parameter int TM_DSC_BITS = 16,
    parameter int QID_W       = 11
) (
    input  logic                   axi_aclk,
    input  logic                   axi_areset,
    input  logic                   sched_en,
    input  logic [QID_W-1:0]       qid_base,
    input  logic [QID_W-1:0]       num_queue,
    input  logic                   credit_updt,
    input  logic [QID_W-1:0]       credit_qid,
    input  logic [TM_DSC_BITS-1:0] credit_in,
    output logic                   grant_valid,
    output logic [QID_W-1:0]       grant_qid,
    input  logic                   grant_ready,
    input  logic                   pkt_valid,
    input  logic                   pkt_ready,
    input  logic                   pkt_last,
    output logic [NUM_Q-1:0]       credit_avail,
    output logic [15:0]            bad_credit_cnt
`ifdef SCHED_STATS_EN
    ,
    output logic [NUM_Q*32-1:0]    grant_cnt
`endif
);
    localparam int SW = $clog2(NUM_Q);
    localparam logic [SW:0] NQ_MAX = (SW+1)'(NUM_Q);

    typedef enum logic [1:0] {IDLE, ARB, GRANT, BUSY} state_t;

    state_t                                 state;
    logic   [SW-1:0]                        rr_ptr;
    logic   [SW-1:0]                        gslot;
    logic   [NUM_Q-1:0][TM_DSC_BITS-1:0]    cnt;
    logic   [NUM_Q-1:0]                     add_en;
    logic   [NUM_Q-1:0]                     dec;

    // Effective window size, clamped to 1..NUM_Q.
    logic [SW:0] nq;
    always_comb begin
        if (num_queue == '0)                  nq = (SW+1)'(1);
        else if (num_queue > QID_W'(NUM_Q))   nq = NQ_MAX;
        else                                  nq = num_queue[SW:0];
    end

    // Credit window decode; the subtraction wraps in QID_W, so the
    // qid >= base test is what rejects qids below the window.
    logic [QID_W-1:0] cslot;
    logic             cvalid;
    assign cslot  = credit_qid - qid_base;
    assign cvalid = (credit_qid >= qid_base) && (cslot < QID_W'(nq));

    wire accept = (state == GRANT) && grant_valid && grant_ready;

    for (genvar i = 0; i < NUM_Q; i++) begin : g_slot
        assign add_en[i] = sched_en && credit_updt && cvalid && (cslot[SW-1:0] == SW'(i));
        assign dec[i]    = accept && (gslot == SW'(i));
        c2h_qs_slot #(.CW(TM_DSC_BITS)) u_slot (
            .axi_aclk   (axi_aclk),
            .axi_areset (axi_areset),
            .clr        (!sched_en),
            .add_en     (add_en[i]),
            .add_val    (credit_in),
            .dec        (dec[i]),
            .cnt        (cnt[i]),
            .avail      (credit_avail[i])
        );
    end

    // Round-robin scan from rr_ptr over the active window only. A stale
    // rr_ptr (window shrank) restarts the scan at slot 0.
    logic [SW:0]   start, idx;
    logic          found;
    logic [SW-1:0] pick;
    always_comb begin
        start = ({1'b0, rr_ptr} >= nq) ? '0 : {1'b0, rr_ptr};
        idx   = '0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            idx = start + (SW+1)'(k);
            if (idx >= nq) idx = idx - nq;
            if (!found && ((SW+1)'(k) < nq) && (cnt[idx[SW-1:0]] != '0)) begin
                found = 1'b1;
                pick  = idx[SW-1:0];
            end
        end
    end

    logic [SW:0] rr_nxt;
    assign rr_nxt = {1'b0, gslot} + (SW+1)'(1);

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_qid   <= '0;
            gslot       <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                IDLE: if (sched_en) state <= ARB;
                ARB: begin
                    if (!sched_en) begin
                        state <= IDLE;
                    end else if (found) begin
                        gslot       <= pick;
                        grant_qid   <= qid_base + QID_W'(pick);
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        rr_ptr      <= (rr_nxt >= nq) ? '0 : rr_nxt[SW-1:0];
                        state       <= BUSY;
                    end else if (!sched_en) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                BUSY: if (pkt_valid && pkt_ready && pkt_last) state <= sched_en ? ARB : IDLE;
                default: state <= IDLE;
            endcase
            if (!sched_en) rr_ptr <= '0;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset)
            bad_credit_cnt <= '0;
        else if (sched_en && credit_updt && !cvalid && (bad_credit_cnt != 16'hFFFF))
            bad_credit_cnt <= bad_credit_cnt + 16'd1;
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++)
                if (dec[i]) grant_cnt[32*i +: 32] <= grant_cnt[32*i +: 32] + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_c2h_queue_scheduler.sv
module tb_c2h_queue_scheduler;
    localparam int NUM_Q = 8;
    localparam int TM    = 16;
    localparam int QW    = 11;

    logic            axi_aclk = 1'b0;
    logic            axi_areset;
    logic            sched_en;
    logic [QW-1:0]   qid_base, num_queue, credit_qid, grant_qid;
    logic            credit_updt, grant_valid, grant_ready;
    logic [TM-1:0]   credit_in;
    logic            pkt_valid, pkt_ready, pkt_last;
    logic [NUM_Q-1:0] credit_avail;
    logic [15:0]     bad_credit_cnt;
`ifdef SCHED_STATS_EN
    logic [NUM_Q*32-1:0] grant_cnt;
`endif

    always #5 axi_aclk = ~axi_aclk;

    c2h_queue_scheduler #(.NUM_Q(NUM_Q), .TM_DSC_BITS(TM), .QID_W(QW)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset), .sched_en(sched_en),
        .qid_base(qid_base), .num_queue(num_queue), .credit_updt(credit_updt),
        .credit_qid(credit_qid), .credit_in(credit_in), .grant_valid(grant_valid),
        .grant_qid(grant_qid), .grant_ready(grant_ready), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_last(pkt_last), .credit_avail(credit_avail),
        .bad_credit_cnt(bad_credit_cnt)
`ifdef SCHED_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    int n_chk = 0, n_fail = 0;

    // Reference model: credits per slot, next-start pointer, bad-update count.
    int mcred[NUM_Q];
    int mrr;
    int mbad;
    int gq[$];

    typedef struct {
        logic [QW-1:0] base;
        logic [QW-1:0] nq;
        logic [QW-1:0] qid;
        logic [TM-1:0] amt;
        int            exp_bad;
        logic [7:0]    exp_avail;
        logic          exp_gv;
        logic [QW-1:0] exp_gqid;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    function automatic int eff_nq();
        if (num_queue == 0) return 1;
        if (int'(num_queue) > NUM_Q) return NUM_Q;
        return int'(num_queue);
    endfunction

    function automatic int model_pick();
        int n, s, i;
        n = eff_nq();
        s = (mrr >= n) ? 0 : mrr;
        for (int k = 0; k < n; k++) begin
            i = (s + k) % n;
            if (mcred[i] > 0) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_avail();
        logic [7:0] a;
        for (int i = 0; i < NUM_Q; i++) a[i] = (mcred[i] > 0);
        return a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_Q; i++) mcred[i] = 0;
        mrr = 0;
    endtask

    task automatic do_reset();
        axi_areset = 1'b1; sched_en = 1'b0; credit_updt = 1'b0; credit_qid = '0;
        credit_in = '0; grant_ready = 1'b0; pkt_valid = 1'b0; pkt_ready = 1'b1;
        pkt_last = 1'b0; qid_base = 11'd8; num_queue = 11'd4;
        tick(); tick();
        axi_areset = 1'b0;
        model_clear();
        mbad = 0;
    endtask

    task automatic model_credit(input logic [QW-1:0] qid, input logic [TM-1:0] amt);
        int d;
        if (!sched_en) return;
        d = int'(qid) - int'(qid_base);
        if (d >= 0 && d < eff_nq()) mcred[d] += int'(amt);
        else if (mbad < 65535) mbad++;
    endtask

    task automatic send_credit(input logic [QW-1:0] qid, input logic [TM-1:0] amt);
        credit_updt = 1'b1; credit_qid = qid; credit_in = amt;
        model_credit(qid, amt);
        tick();
        credit_updt = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (grant_valid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Check the offered grant against the model, accept it, and optionally
    // run a single-beat packet.
    task automatic take_grant(input bit hold, output int got);
        int e, n;
        logic [QW-1:0] eq;
        e = model_pick();
        n = eff_nq();
        chk("grant_offer", {63'd0, grant_valid}, {63'd0, (e >= 0)});
        if (e >= 0) begin
            eq = qid_base + QW'(e);
            chk("grant_qid", {53'd0, grant_qid}, {53'd0, eq});
        end
        got = int'(grant_qid);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        if (e >= 0) begin
            mcred[e]--;
            mrr = (e + 1) % n;
        end
        if (!hold) begin
            pkt_valid = 1'b1; pkt_ready = 1'b1; pkt_last = 1'b1;
            tick();
            pkt_valid = 1'b0; pkt_last = 1'b0;
        end
    endtask

    task automatic drain();
        bit ok;
        int g, guard;
        gq.delete();
        guard = 0;
        while (model_pick() >= 0 && guard < 200) begin
            guard++;
            wait_grant(ok);
            chk("drain_grant_seen", {63'd0, ok}, 64'd1);
            if (!ok) break;
            take_grant(1'b0, g);
            gq.push_back(g);
        end
        repeat (8) tick();
        chk("drain_idle", {63'd0, grant_valid}, 64'd0);
        chk("drain_avail", {56'd0, credit_avail}, {56'd0, model_avail()});
    endtask

    initial begin
        bit ok;
        int g, gv_seen, tbad;
        int exp2[8] = '{8, 9, 10, 11, 8, 9, 10, 11};

        tbl[0]  = '{11'd8,    11'd4,  11'd8,    16'd2, 0, 8'h01, 1'b1, 11'd8};
        tbl[1]  = '{11'd8,    11'd4,  11'd11,   16'd1, 0, 8'h08, 1'b1, 11'd11};
        tbl[2]  = '{11'd8,    11'd4,  11'd12,   16'd1, 1, 8'h00, 1'b0, 11'd0};
        tbl[3]  = '{11'd8,    11'd4,  11'd7,    16'd1, 1, 8'h00, 1'b0, 11'd0};
        tbl[4]  = '{11'd8,    11'd0,  11'd8,    16'd1, 0, 8'h01, 1'b1, 11'd8};
        tbl[5]  = '{11'd8,    11'd0,  11'd9,    16'd1, 1, 8'h00, 1'b0, 11'd0};
        tbl[6]  = '{11'd0,    11'd15, 11'd7,    16'd1, 0, 8'h80, 1'b1, 11'd7};
        tbl[7]  = '{11'd0,    11'd15, 11'd8,    16'd1, 1, 8'h00, 1'b0, 11'd0};
        tbl[8]  = '{11'd2040, 11'd8,  11'd2047, 16'd1, 0, 8'h80, 1'b1, 11'd2047};
        tbl[9]  = '{11'd2040, 11'd8,  11'd3,    16'd1, 1, 8'h00, 1'b0, 11'd0};
        tbl[10] = '{11'd5,    11'd8,  11'd5,    16'd0, 0, 8'h00, 1'b0, 11'd0};
        tbl[11] = '{11'd100,  11'd3,  11'd102,  16'd5, 0, 8'h04, 1'b1, 11'd102};

        // Reset values, then 100 idle cycles with sched_en=1 and no credits.
        do_reset();
        axi_areset = 1'b1; sched_en = 1'b1;
        tick();
        chk("rst_gv", {63'd0, grant_valid}, 64'd0);
        chk("rst_gqid", {53'd0, grant_qid}, 64'd0);
        chk("rst_avail", {56'd0, credit_avail}, 64'd0);
        chk("rst_bad", {48'd0, bad_credit_cnt}, 64'd0);
        axi_areset = 1'b0;
        gv_seen = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (grant_valid) gv_seen++; end
        chk("idle_no_grant", 64'(gv_seen), 64'd0);
        chk("idle_avail", {56'd0, credit_avail}, 64'd0);

        // Window decode table: each vector starts from cleared credits.
        do_reset();
        tbad = 0;
        for (int v = 0; v < 12; v++) begin
            sched_en = 1'b0; tick();
            sched_en = 1'b1; qid_base = tbl[v].base; num_queue = tbl[v].nq;
            credit_updt = 1'b1; credit_qid = tbl[v].qid; credit_in = tbl[v].amt;
            tick();
            credit_updt = 1'b0;
            tick();
            tbad += tbl[v].exp_bad;
            chk($sformatf("tbl%0d_bad", v), {48'd0, bad_credit_cnt}, 64'(tbad));
            chk($sformatf("tbl%0d_avail", v), {56'd0, credit_avail}, {56'd0, tbl[v].exp_avail});
            chk($sformatf("tbl%0d_gv", v), {63'd0, grant_valid}, {63'd0, tbl[v].exp_gv});
            if (tbl[v].exp_gv)
                chk($sformatf("tbl%0d_gqid", v), {53'd0, grant_qid}, {53'd0, tbl[v].exp_gqid});
        end

        // Four queues, two credits each: strict 8,9,10,11 rotation twice.
        do_reset();
        sched_en = 1'b1; qid_base = 11'd8; num_queue = 11'd4;
        for (int q = 8; q < 12; q++) send_credit(QW'(q), 16'd2);
        drain();
        chk("rr_count", 64'(gq.size()), 64'd8);
        for (int i = 0; i < 8 && i < gq.size(); i++)
            chk($sformatf("rr_order%0d", i), 64'(gq[i]), 64'(exp2[i]));
`ifdef SCHED_STATS_EN
        for (int i = 0; i < NUM_Q; i++)
            chk($sformatf("grant_cnt%0d", i), {32'd0, grant_cnt[32*i +: 32]}, (i < 4) ? 64'd2 : 64'd0);
`endif

        // Credit update and grant accept on the same slot in one cycle.
        do_reset();
        sched_en = 1'b1; qid_base = 11'd8; num_queue = 11'd4;
        send_credit(11'd8, 16'd1);
        wait_grant(ok);
        chk("same_cyc_gv", {63'd0, ok}, 64'd1);
        chk("same_cyc_gqid", {53'd0, grant_qid}, 64'd8);
        grant_ready = 1'b1; credit_updt = 1'b1; credit_qid = 11'd8; credit_in = 16'd3;
        tick();
        grant_ready = 1'b0; credit_updt = 1'b0;
        mcred[0] = 1 + 3 - 1; mrr = 1;
        pkt_valid = 1'b1; pkt_last = 1'b1; tick(); pkt_valid = 1'b0; pkt_last = 1'b0;
        chk("same_cyc_avail", {56'd0, credit_avail}, 64'h01);
        drain();
        chk("same_cyc_grants", 64'(gq.size()), 64'd3);
        for (int i = 0; i < gq.size(); i++) chk("same_cyc_qid", 64'(gq[i]), 64'd8);

        // sched_en drops while a packet is in flight.
        do_reset();
        sched_en = 1'b1; qid_base = 11'd8; num_queue = 11'd4;
        send_credit(11'd8, 16'd2);
        send_credit(11'd9, 16'd1);
        wait_grant(ok);
        chk("drop_gv", {63'd0, ok}, 64'd1);
        take_grant(1'b1, g);
        sched_en = 1'b0;
        pkt_valid = 1'b1; pkt_ready = 1'b1; pkt_last = 1'b0;
        repeat (3) begin tick(); model_clear(); end
        chk("drop_busy_gv", {63'd0, grant_valid}, 64'd0);
        pkt_last = 1'b1; tick(); pkt_valid = 1'b0; pkt_last = 1'b0;
        repeat (3) tick();
        chk("drop_avail", {56'd0, credit_avail}, 64'd0);
        sched_en = 1'b1;
        gv_seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (grant_valid) gv_seen++; end
        chk("drop_no_regrant", 64'(gv_seen), 64'd0);
        send_credit(11'd10, 16'd1);
        wait_grant(ok);
        chk("drop_new_gv", {63'd0, ok}, 64'd1);
        if (ok) take_grant(1'b0, g);

        // Random rounds: hold a packet open, reshape the window, pour in
        // random credits (some out of window), then drain against the model.
        do_reset();
        sched_en = 1'b1; qid_base = 11'd0; num_queue = 11'd8;
        for (int r = 0; r < 30; r++) begin
            int nu;
            logic [QW-1:0] q;
            send_credit(qid_base, 16'd1);
            wait_grant(ok);
            chk("rnd_kick", {63'd0, ok}, 64'd1);
            if (ok) take_grant(1'b1, g);
            num_queue = QW'($urandom_range(0, 10));
            qid_base  = QW'($urandom_range(0, 2047));
            nu = $urandom_range(0, 12);
            for (int u = 0; u < nu; u++) begin
                if ($urandom_range(0, 9) == 0) q = QW'($urandom_range(0, 2047));
                else q = qid_base + QW'($urandom_range(0, 9));
                send_credit(q, TM'($urandom_range(0, 3)));
                if ($urandom_range(0, 1) == 1) tick();
            end
            chk("rnd_busy_gv", {63'd0, grant_valid}, 64'd0);
            pkt_valid = 1'b1; pkt_last = 1'b1; pkt_ready = 1'b0; tick();
            pkt_ready = 1'b1; tick();
            pkt_valid = 1'b0; pkt_last = 1'b0;
            drain();
            chk("rnd_bad", {48'd0, bad_credit_cnt}, 64'(mbad));
        end

        // Out-of-window updates saturate the bad counter.
        do_reset();
        sched_en = 1'b1; qid_base = 11'd8; num_queue = 11'd4;
        credit_updt = 1'b1; credit_qid = 11'd20; credit_in = 16'd1;
        tick();
        chk("bad_first", {48'd0, bad_credit_cnt}, 64'd1);
        repeat (69999) tick();
        credit_updt = 1'b0;
        tick();
        chk("bad_sat", {48'd0, bad_credit_cnt}, 64'hFFFF);
        chk("bad_no_grant", {63'd0, grant_valid}, 64'd0);
        chk("bad_avail", {56'd0, credit_avail}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
